// File: rtl/fetch_byte_queue.sv
// Byte ring between instruction memory and the x86 decoder.
// Ports: clk/rstn, flush/flush_pc, mem_req/addr/ack/rdata, win_*, consume/len.
module fetch_byte_queue #(
    parameter int unsigned FBQ_BYTES = 16,
    parameter int unsigned WIN_BYTES = 15,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic [8*WIN_BYTES-1:0] win_bytes,
    output logic [3:0]             win_cnt,
    output logic [31:0]            win_pc,
    input  logic                   consume,
    input  logic [3:0]             consume_len
);

    localparam int PW = $clog2(FBQ_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t        state;
    logic [7:0]    ring [FBQ_BYTES];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;

    logic [1:0]    off;
    logic [2:0]    n;
    logic          wr;
    logic          cons_ok;
    logic          do_cons;
    logic [CW-1:0] cons_amt;
    logic [CW-1:0] wr_amt;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] free_now;
    logic [CW-1:0] free_nxt;
    logic          room_now;
    logic          room_nxt;

    // A misaligned fetch PC only delivers the upper bytes of the word.
    assign off = fetch_pc[1:0];
    assign n   = 3'd4 - {1'b0, off};
    assign wr  = (state == REQ) && mem_ack && !flush;

    assign cons_ok  = consume && (consume_len != 4'd0) &&
                      (consume_len <= win_cnt);
    assign do_cons  = cons_ok && !flush;
    assign cons_amt = do_cons ? CW'(consume_len) : '0;
    assign wr_amt   = wr ? CW'(n) : '0;

    assign count_nxt = count - cons_amt + wr_amt;
    assign free_now  = CW'(FBQ_BYTES) - count;
    assign free_nxt  = CW'(FBQ_BYTES) - count_nxt;
    assign room_now  = free_now >= CW'(4);
    assign room_nxt  = free_nxt >= CW'(4);

    assign win_cnt = (count > CW'(WIN_BYTES)) ? 4'(WIN_BYTES) : 4'(count);

    always_comb begin
        win_bytes = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            if (4'(i) < win_cnt) begin
                win_bytes[8*i +: 8] = ring[head + PW'(i)];
            end
        end
    end

    // Ring contents need no reset: win_cnt masks anything not yet written.
    always_ff @(posedge clk) begin
        if (rstn && wr) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) >= off) begin
                    ring[tail + PW'(k) - PW'(off)] <= mem_rdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            win_pc   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            win_pc   <= flush_pc;
            fetch_pc <= flush_pc;
            unique case (state)
                REQ: begin
                    // An unacked request must still be drained before
                    // the redirected fetch can go out.
                    if (mem_ack) begin
                        mem_addr <= {flush_pc[31:2], 2'b00};
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_addr <= {flush_pc[31:2], 2'b00};
                    end
                end
                default: begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= {flush_pc[31:2], 2'b00};
                end
            endcase
        end else begin
            count <= count_nxt;
            if (do_cons) begin
                head   <= head + PW'(consume_len);
                win_pc <= win_pc + 32'(consume_len);
            end
            if (wr) begin
                tail <= tail + PW'(n);
            end
            unique case (state)
                IDLE: begin
                    if (room_now) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= {fetch_pc[31:2], 2'b00};
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetch_pc <= mem_addr + 32'd4;
                        if (room_nxt) begin
                            mem_addr <= mem_addr + 32'd4;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_addr <= {fetch_pc[31:2], 2'b00};
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    consume_legal: assert property (
        @(posedge clk) disable iff (!rstn)
        consume |-> (consume_len != 4'd0 && consume_len <= win_cnt)
    );

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Self-checking bench for fetch_byte_queue.
// Byte scoreboard plus per-cycle request and window checks.
module tb_fetch_byte_queue;

    localparam int WIN = 15;

    logic           clk = 1'b0;
    logic           rstn;
    logic           flush;
    logic [31:0]    flush_pc;
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_ack;
    logic [31:0]    mem_rdata;
    logic [8*WIN-1:0] win_bytes;
    logic [3:0]     win_cnt;
    logic [31:0]    win_pc;
    logic           consume;
    logic [3:0]     consume_len;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    bit          m_out;
    bit          m_drain;

    typedef struct {
        bit          fl;
        logic [31:0] fpc;
        bit          ack;
        logic [31:0] rd;
        bit          cons;
        logic [3:0]  len;
        bit          e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_cnt;
        logic [31:0] e_lo;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[12];

    fetch_byte_queue dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .win_bytes   (win_bytes),
        .win_cnt     (win_cnt),
        .win_pc      (win_pc),
        .consume     (consume),
        .consume_len (consume_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_window(input string nm);
        logic [8*WIN-1:0] ew;
        int c;
        c  = (sb.size() > WIN) ? WIN : sb.size();
        ew = '0;
        for (int i = 0; i < c; i++) ew[8*i +: 8] = sb[i];
        chk({nm, " win_cnt"}, 32'(win_cnt), 32'(c));
        chk({nm, " win_pc"}, win_pc, m_pc);
        checks++;
        if (win_bytes !== ew) begin
            errors++;
            $display("FAIL %s win_bytes actual=%h expected=%h",
                     nm, win_bytes, ew);
        end
    endtask

    task automatic apply(input string nm, input bit fl,
                         input logic [31:0] fpc, input bit ack,
                         input logic [31:0] rd, input bit cons,
                         input logic [3:0] len, input bit ereq,
                         input logic [31:0] eaddr);
        flush       = fl;
        flush_pc    = fpc;
        mem_ack     = ack;
        mem_rdata   = rd;
        consume     = cons;
        consume_len = len;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        consume     = 1'b0;
        consume_len = 4'd0;
        if (fl) begin
            m_drain = m_out && !ack;
            sb.delete();
            m_pc  = fpc;
            m_fpc = fpc;
        end else begin
            if (cons) begin
                repeat (int'(len)) void'(sb.pop_front());
                m_pc = m_pc + 32'(len);
            end
            if (ack && m_out) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                end else begin
                    for (int k = int'(m_fpc[1:0]); k < 4; k++) begin
                        sb.push_back(rd[8*k +: 8]);
                    end
                    m_fpc = {m_fpc[31:2], 2'b00} + 32'd4;
                end
            end
        end
        check_window(nm);
        chk({nm, " mem_req"}, 32'(mem_req), 32'(ereq));
        if (ereq) chk({nm, " mem_addr"}, mem_addr, eaddr);
        m_out = ereq;
    endtask

    initial begin
        vt[0]  = '{0, 0, 0, 0, 0, 0, 1, 32'h0,  0, 32'h0, 32'h0};
        vt[1]  = '{0, 0, 1, 32'h44332211, 0, 0, 1, 32'h4,  4,
                   32'h44332211, 32'h0};
        vt[2]  = '{0, 0, 1, 32'h88776655, 0, 0, 1, 32'h8,  8,
                   32'h44332211, 32'h0};
        vt[3]  = '{0, 0, 1, 32'hCCBBAA99, 0, 0, 1, 32'hC,  12,
                   32'h44332211, 32'h0};
        vt[4]  = '{0, 0, 1, 32'h100FEEDD, 0, 0, 0, 32'h0,  15,
                   32'h44332211, 32'h0};
        vt[5]  = '{0, 0, 0, 0, 1, 3, 0, 32'h0,  13,
                   32'h77665544, 32'h3};
        vt[6]  = '{0, 0, 0, 0, 1, 1, 0, 32'h0,  12,
                   32'h88776655, 32'h4};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 1, 32'h10, 12,
                   32'h88776655, 32'h4};
        vt[8]  = '{0, 0, 1, 32'h14131211, 0, 0, 0, 32'h0,  15,
                   32'h88776655, 32'h4};
        vt[9]  = '{1, 32'h103, 0, 0, 0, 0, 1, 32'h100, 0,
                   32'h0, 32'h103};
        vt[10] = '{0, 0, 1, 32'hDDCCBBAA, 0, 0, 1, 32'h104, 1,
                   32'h000000DD, 32'h103};
        vt[11] = '{0, 0, 1, 32'h07060504, 0, 0, 1, 32'h108, 5,
                   32'h060504DD, 32'h103};

        rstn        = 1'b0;
        flush       = 1'b0;
        flush_pc    = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        consume     = 1'b0;
        consume_len = 4'd0;
        m_pc = 0; m_fpc = 0; m_out = 0; m_drain = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        check_window("rst");
        rstn = 1'b1;

        for (int r = 0; r < 12; r++) begin
            apply($sformatf("row%0d", r), vt[r].fl, vt[r].fpc,
                  vt[r].ack, vt[r].rd, vt[r].cons, vt[r].len,
                  vt[r].e_req, vt[r].e_addr);
            chk($sformatf("row%0d cnt", r), 32'(win_cnt), 32'(vt[r].e_cnt));
            chk($sformatf("row%0d lo", r), win_bytes[31:0], vt[r].e_lo);
            chk($sformatf("row%0d pc", r), win_pc, vt[r].e_pc);
        end

        // flush with a late ack, then a second flush while draining
        apply("t4 wait", 0, 0, 0, 0, 0, 0, 1, 32'h108);
        apply("t4 fl1", 1, 32'h200, 0, 0, 0, 0, 1, 32'h108);
        apply("t4 fl2", 1, 32'h302, 0, 0, 0, 0, 1, 32'h108);
        apply("t4 stale", 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 32'h300);
        chk("t4 dropped", 32'(win_cnt), 32'h0);
        apply("t4 new", 0, 0, 1, 32'h33323130, 0, 0, 1, 32'h304);
        chk("t4 bytes", 32'(win_bytes[15:0]), 32'h3332);
        chk("t4 pc", win_pc, 32'h302);
        apply("t4 more", 0, 0, 1, 32'h37363534, 0, 0, 1, 32'h308);

        // bring head to 14 with 12 bytes, then consume 5 alongside an ack
        apply("t5 flack", 1, 32'h402, 1, 32'hBAD0BAD0, 0, 0, 1, 32'h400);
        apply("t5 a0", 0, 0, 1, 32'h03020100, 0, 0, 1, 32'h404);
        apply("t5 a1", 0, 0, 1, 32'h07060504, 0, 0, 1, 32'h408);
        apply("t5 a2", 0, 0, 1, 32'h0B0A0908, 0, 0, 1, 32'h40C);
        apply("t5 a3", 0, 0, 1, 32'h0F0E0D0C, 0, 0, 0, 32'h0);
        apply("t5 c14", 0, 0, 0, 0, 1, 4'd14, 0, 32'h0);
        apply("t5 idle", 0, 0, 0, 0, 0, 0, 1, 32'h410);
        apply("t5 a4", 0, 0, 1, 32'h13121110, 0, 0, 1, 32'h414);
        apply("t5 a5", 0, 0, 1, 32'h17161514, 0, 0, 1, 32'h418);
        apply("t5 a6", 0, 0, 1, 32'h1B1A1918, 0, 0, 1, 32'h41C);
        apply("t5 both", 0, 0, 1, 32'h1F1E1D1C, 1, 4'd5, 1, 32'h420);
        chk("t5 cnt", 32'(win_cnt), 32'd11);
        chk("t5 pc", win_pc, 32'h415);
        chk("t5 lo", win_bytes[31:0], 32'h18171615);

        // flush beats consume; reset beats everything
        apply("t6 flcons", 1, 32'h500, 0, 0, 1, 4'd2, 1, 32'h420);
        chk("t6 pc", win_pc, 32'h500);
        apply("t6 stale", 0, 0, 1, 32'hFFFFFFFF, 0, 0, 1, 32'h500);
        apply("t6 new", 0, 0, 1, 32'h53525150, 0, 0, 1, 32'h504);
        rstn      = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        sb.delete();
        m_pc = 0; m_fpc = 0; m_out = 0; m_drain = 0;
        chk("t6 rst req", 32'(mem_req), 32'h0);
        check_window("t6 rst");
        rstn = 1'b1;
        apply("t6 up", 0, 0, 0, 0, 0, 0, 1, 32'h0);
        apply("t6 ack", 0, 0, 1, 32'h44332211, 0, 0, 1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
